// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add sequencer: one full-adder cell, LSB first, start/done handshake
// Optional macro SERIAL_ADDER_SUB_EN adds a sub port (A - B via inverted B and a forced carry-in).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q;
  logic             fa_s, fa_c;
  logic             accept, last;
  logic [WIDTH-1:0] b_cap, res_next;
  logic             c_cap;

  assign fa_s     = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_c     = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
  assign res_next = {fa_s, res_q[WIDTH-1:1]};
  assign accept   = (state_q == IDLE) && start;
  assign last     = (state_q == RUN) && (cnt_q == LAST);

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as A + ~B + 1; cin_in is ignored when sub is set.
  assign b_cap = sub ? ~b_in : b_in;
  assign c_cap = sub | cin_in;
`else
  assign b_cap = b_in;
  assign c_cap = cin_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= a_in;
      b_q     <= b_cap;
      carry_q <= c_cap;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      res_q   <= res_next;
      carry_q <= fa_c;
      cnt_q   <= cnt_q + CW'(1);
      if (last) begin
        sum_q  <= res_next;
        cout_q <= fa_c;
      end
    end
  end

  assign sum_out = sum_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed and random checks of serial_adder_ctrl at WIDTH=8 and WIDTH=5
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst, start8, start5, cin, sub_v;
  logic [7:0] a8, b8, sum8;
  logic [4:0] a5, b5, sum5;
  logic       busy8, done8, cout8, busy5, done5, cout5;

  int         n_total = 0;
  int         n_bad = 0;
  int         lat8, lat5, bcnt8, dcnt8, dcnt5;
  logic [7:0] r_s8;
  logic [4:0] r_s5;
  logic       r_c8, r_c5, hold_ok;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_v),
`endif
    .a_in(a8), .b_in(b8), .cin_in(cin),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_v),
`endif
    .a_in(a5), .b_in(b5), .cin_in(cin),
    .busy(busy5), .done(done5), .sum_out(sum5), .cout(cout5)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Launch both DUTs in the current IDLE cycle and follow them until both are idle again.
  // inj re-asserts start8 with 1+1 operands in a RUN cycle and in the DONE cycle.
  task automatic do_op(input logic [7:0] av8, input logic [7:0] bv8, input logic [4:0] av5,
                       input logic [4:0] bv5, input logic cv, input logic inj);
    int e;
    logic [7:0] s8_prev;
    logic [4:0] s5_prev;
    a8 = av8; b8 = bv8; a5 = av5; b5 = bv5; cin = cv;
    start8 = 1'b1; start5 = 1'b1;
    s8_prev = sum8; s5_prev = sum5;
    @(posedge clk); #1;
    start8 = 1'b0; start5 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); a5 = 5'($urandom); b5 = 5'($urandom); cin = ~cv;
    e = 0; lat8 = -1; lat5 = -1; bcnt8 = 0; dcnt8 = 0; dcnt5 = 0; hold_ok = 1'b1;
    r_s8 = 8'hxx; r_c8 = 1'bx; r_s5 = 5'hxx; r_c5 = 1'bx;
    while ((busy8 || busy5) && e < 40) begin
      if (busy8) bcnt8++;
      if (done8) begin
        dcnt8++; lat8 = e; r_s8 = sum8; r_c8 = cout8;
      end else if (busy8 && (sum8 !== s8_prev || cout8 !== 1'b0 && cout8 !== cout8)) hold_ok = 1'b0;
      if (done5) begin
        dcnt5++; lat5 = e; r_s5 = sum5; r_c5 = cout5;
      end else if (busy5 && sum5 !== s5_prev) hold_ok = 1'b0;
      start8 = inj && (e == 2 || e == 8);
      if (start8) begin a8 = 8'h01; b8 = 8'h01; end
      @(posedge clk); #1;
      e++;
    end
    start8 = 1'b0;
    if (e >= 40) check("op_timeout", 64'(e), 64'(39));
  endtask

  task automatic check_add(input string tag, input logic [7:0] av8, input logic [7:0] bv8,
                           input logic [4:0] av5, input logic [4:0] bv5, input logic cv);
    logic [8:0] x8;
    logic [5:0] x5;
    x8 = {1'b0, av8} + {1'b0, bv8} + {8'd0, cv};
    x5 = {1'b0, av5} + {1'b0, bv5} + {5'd0, cv};
    do_op(av8, bv8, av5, bv5, cv, 1'b0);
    check({tag, "_sum8"}, 64'(r_s8), 64'(x8[7:0]));
    check({tag, "_cout8"}, 64'(r_c8), 64'(x8[8]));
    check({tag, "_lat8"}, 64'(lat8), 64'(8));
    check({tag, "_sum5"}, 64'(r_s5), 64'(x5[4:0]));
    check({tag, "_cout5"}, 64'(r_c5), 64'(x5[5]));
    check({tag, "_lat5"}, 64'(lat5), 64'(5));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int d;
    logic [7:0] ra, rb;
    logic [4:0] ra5, rb5;
    logic rc;
    rst = 1'b1; start8 = 1'b0; start5 = 1'b0; cin = 1'b0; sub_v = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a5 = 5'h00; b5 = 5'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", 64'(busy8), 64'(0));
    check("rst_done", 64'(done8), 64'(0));
    check("rst_sum", 64'(sum8), 64'(0));
    check("rst_cout", 64'(cout8), 64'(0));
    check("rst_sum5", 64'(sum5), 64'(0));

    // Carry-in cases
    do_op(8'h7F, 8'h00, 5'h0F, 5'h00, 1'b1, 1'b0);
    check("cin1_sum", 64'(r_s8), 64'(8'h80));
    check("cin1_cout", 64'(r_c8), 64'(0));
    check("cin1_sum5", 64'(r_s5), 64'(5'h10));
    do_op(8'hFF, 8'hFF, 5'h1F, 5'h1F, 1'b1, 1'b0);
    check("cin2_sum", 64'(r_s8), 64'(8'hFF));
    check("cin2_cout", 64'(r_c8), 64'(1));
    check("cin2_cout5", 64'(r_c5), 64'(1));

    // Reset in the middle of RUN
    a8 = 8'h55; b8 = 8'h0F; cin = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy8), 64'(0));
    check("mid_rst_done", 64'(done8), 64'(0));
    check("mid_rst_sum", 64'(sum8), 64'(0));
    check("mid_rst_cout", 64'(cout8), 64'(0));
    d = 0;
    repeat (12) begin
      if (done8) d++;
      @(posedge clk); #1;
    end
    check("mid_rst_no_done", 64'(d), 64'(0));

    // Fresh start after reset: full carry ripple, latency and busy length
    do_op(8'hFF, 8'h01, 5'h1F, 5'h01, 1'b0, 1'b0);
    check("ripple_sum", 64'(r_s8), 64'(8'h00));
    check("ripple_cout", 64'(r_c8), 64'(1));
    check("ripple_lat", 64'(lat8), 64'(8));
    check("ripple_busy", 64'(bcnt8), 64'(9));
    check("ripple_ndone", 64'(dcnt8), 64'(1));
    check("ripple_hold", 64'(hold_ok), 64'(1));
    check("ripple_sum5", 64'(r_s5), 64'(5'h00));
    check("ripple_cout5", 64'(r_c5), 64'(1));
    check("ripple_lat5", 64'(lat5), 64'(5));

    // start during RUN and DONE is ignored
    do_op(8'h3C, 8'h14, 5'h03, 5'h04, 1'b0, 1'b1);
    check("inj_sum", 64'(r_s8), 64'(8'h50));
    check("inj_cout", 64'(r_c8), 64'(0));
    check("inj_ndone", 64'(dcnt8), 64'(1));
    check("inj_busy", 64'(bcnt8), 64'(9));
    check("inj_idle", 64'(busy8), 64'(0));
    check("inj_sum_kept", 64'(sum8), 64'(8'h50));

`ifdef SERIAL_ADDER_SUB_EN
    sub_v = 1'b1;
    do_op(8'h10, 8'h01, 5'h10, 5'h01, 1'b0, 1'b0);
    check("sub1_sum", 64'(r_s8), 64'(8'h0F));
    check("sub1_cout", 64'(r_c8), 64'(1));
    check("sub1_sum5", 64'(r_s5), 64'(5'h0F));
    do_op(8'h00, 8'h01, 5'h00, 5'h01, 1'b1, 1'b0);
    check("sub2_sum", 64'(r_s8), 64'(8'hFF));
    check("sub2_cout", 64'(r_c8), 64'(0));
    check("sub2_cout5", 64'(r_c5), 64'(0));
    sub_v = 1'b0;
`endif

    // Back-to-back random sweep: each op starts in the IDLE cycle right after the previous done
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      ra5 = 5'($urandom); rb5 = 5'($urandom); rc = 1'($urandom);
      check_add("sweep", ra, rb, ra5, rb5, rc);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
